tl_qspi_arb: RTL and testbench

- Sequencing arbiter that shares the single QSPI TL-UL device port between M host-side paths (IFU fetch path, LSU path).
- Sits between the per-host 1:N sockets and the QSPI controller in the main crossbar.
- Round-robin grant; one outstanding transaction at a time.
- Response-timeout watchdog returns a TL-UL error so a hung flash cannot lock either host.

---
 rtl/tl_main_pkg.sv | 13 +
 rtl/tlul_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/tl_qspi_arb.sv | 170 +++++++++++++++++
 tb/tb_tl_qspi_arb.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_main_pkg.sv
// Main-crossbar local types: QSPI arbiter state and watchdog default.
package tl_main_pkg;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbIssue,
        ArbWait,
        ArbDrain
    } arb_state_e;

    localparam int unsigned DefTimeoutCycles = 1024;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by the crossbar blocks.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/rr_arbiter.sv
// M-way round-robin pick: first requester at or after ptr_i, modulo M.
module rr_arbiter #(
    parameter int unsigned M    = 2,
    parameter int unsigned IdxW = (M > 1) ? $clog2(M) : 1
) (
    input  logic [M-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [M-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic        found;
    int unsigned cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < M; off++) begin
            cand = (32'(ptr_i) + off) % M;
            if (!found && req_i[IdxW'(cand)]) begin
                found              = 1'b1;
                idx_o              = IdxW'(cand);
                gnt_o[IdxW'(cand)] = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/tl_qspi_arb.sv
// Shares the single QSPI TL-UL device port between M host paths, one transaction at a time.
module tl_qspi_arb
    import tlul_pkg::*;
    import tl_main_pkg::*;
#(
    parameter int unsigned M             = 2,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles,
    parameter int unsigned CntW          = 11
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h_i [M],
    output tl_d2h_t tl_h_o [M],
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i,
    output logic [M-1:0] grant_o,
    output logic    busy_o,
    output logic    timeout_o,
    output logic    stray_rsp_o
);

    localparam int unsigned IdxW = (M > 1) ? $clog2(M) : 1;

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] gidx_q, gidx_d;
    logic [M-1:0]    grant_q, grant_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    tl_a_op_e        lat_op_q, lat_op_d;
    logic [7:0]      lat_src_q, lat_src_d;
    logic [1:0]      lat_size_q, lat_size_d;

    logic [M-1:0]    req;
    logic [M-1:0]    arb_gnt;
    logic [IdxW-1:0] arb_idx;
    logic            arb_valid;
    logic [IdxW-1:0] nxt_ptr;
    logic            to_hit;
    tl_h2d_t         g_h2d;

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < M; i++) begin
            req[i] = tl_h_i[i].a_valid;
        end
    end

    rr_arbiter #(.M(M), .IdxW(IdxW)) u_rr (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign nxt_ptr = (gidx_q == IdxW'(M - 1)) ? '0 : gidx_q + 1'b1;
    assign g_h2d   = tl_h_i[gidx_q];
    // A device response in the deadline cycle wins over the synthesized error.
    assign to_hit  = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles)) && !tl_d_i.d_valid;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        lat_op_d    = lat_op_q;
        lat_src_d   = lat_src_q;
        lat_size_d  = lat_size_q;
        tl_d_o      = '0;
        timeout_o   = 1'b0;
        stray_rsp_o = 1'b0;
        for (int unsigned i = 0; i < M; i++) begin
            tl_h_o[i] = '0;
        end

        unique case (state_q)
            ArbIdle: begin
                tl_d_o.d_ready = 1'b1;
                stray_rsp_o    = tl_d_i.d_valid;
                if (arb_valid) begin
                    gidx_d     = arb_idx;
                    grant_d    = arb_gnt;
                    lat_op_d   = tl_h_i[arb_idx].a_opcode;
                    lat_src_d  = tl_h_i[arb_idx].a_source;
                    lat_size_d = tl_h_i[arb_idx].a_size;
                    state_d    = ArbIssue;
                end
            end
            ArbIssue: begin
                tl_d_o                 = g_h2d;
                tl_d_o.d_ready         = 1'b0;
                tl_h_o[gidx_q].a_ready = tl_d_i.a_ready;
                if (!g_h2d.a_valid) begin
                    state_d = ArbIdle;
                end else if (tl_d_i.a_ready) begin
                    cnt_d   = '0;
                    state_d = ArbWait;
                end
            end
            ArbWait: begin
                if (to_hit) begin
                    tl_h_o[gidx_q].d_valid  = 1'b1;
                    tl_h_o[gidx_q].d_error  = 1'b1;
                    tl_h_o[gidx_q].d_opcode = (lat_op_q == Get) ? AccessAckData : AccessAck;
                    tl_h_o[gidx_q].d_source = lat_src_q;
                    tl_h_o[gidx_q].d_size   = lat_size_q;
                    if (g_h2d.d_ready) begin
                        timeout_o = 1'b1;
                        state_d   = ArbDrain;
                    end
                end else begin
                    tl_h_o[gidx_q]         = tl_d_i;
                    tl_h_o[gidx_q].a_ready = 1'b0;
                    tl_d_o.d_ready         = g_h2d.d_ready;
                    if (tl_d_i.d_valid && g_h2d.d_ready) begin
                        rr_ptr_d = nxt_ptr;
                        state_d  = ArbIdle;
                    end else if (!tl_d_i.d_valid) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ArbDrain: begin
                tl_d_o.d_ready = 1'b1;
                if (tl_d_i.d_valid) begin
                    rr_ptr_d = nxt_ptr;
                    state_d  = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase

        // Outputs are forced quiet while reset is held, so an abort never leaks a response.
        if (rst_i) begin
            tl_d_o      = '0;
            timeout_o   = 1'b0;
            stray_rsp_o = 1'b0;
            for (int unsigned i = 0; i < M; i++) begin
                tl_h_o[i] = '0;
            end
        end
    end

    assign grant_o = (!rst_i && state_q != ArbIdle) ? grant_q : '0;
    assign busy_o  = !rst_i && (state_q != ArbIdle);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ArbIdle;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            lat_op_q   <= PutFullData;
            lat_src_q  <= '0;
            lat_size_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            lat_op_q   <= lat_op_d;
            lat_src_q  <= lat_src_d;
            lat_size_q <= lat_size_d;
        end
    end

endmodule

// File: tb/tb_tl_qspi_arb.sv
// Directed bench for tl_qspi_arb with a short watchdog (8 cycles).
module tb_tl_qspi_arb;
    import tlul_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    tl_h2d_t h_i [2];
    tl_d2h_t h_o [2];
    tl_h2d_t d_o;
    tl_d2h_t d_i;
    logic [1:0] grant;
    logic    busy, tmo, stray;

    int checks   = 0;
    int failures = 0;
    int hs;
    logic [7:0] cap;

    tl_qspi_arb #(.M(2), .TimeoutCycles(8), .CntW(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tl_h_i      (h_i),
        .tl_h_o      (h_o),
        .tl_d_o      (d_o),
        .tl_d_i      (d_i),
        .grant_o     (grant),
        .busy_o      (busy),
        .timeout_o   (tmo),
        .stray_rsp_o (stray)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dev(input logic v, input tl_d_op_e op, input logic [7:0] src, input logic [31:0] data);
        d_i.d_valid  = v;
        d_i.d_opcode = op;
        d_i.d_source = src;
        d_i.d_size   = 2'd2;
        d_i.d_data   = data;
    endtask

    task automatic host(input int h, input logic v, input tl_a_op_e op, input logic [7:0] src);
        h_i[h].a_valid   = v;
        h_i[h].a_opcode  = op;
        h_i[h].a_source  = src;
        h_i[h].a_size    = 2'd2;
        h_i[h].a_address = 32'h4000_0000;
    endtask

    initial begin
        rst    = 1'b1;
        h_i[0] = '0;
        h_i[1] = '0;
        h_i[0].d_ready = 1'b1;
        h_i[1].d_ready = 1'b1;
        d_i = '0;
        d_i.a_ready = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_dready", d_o.d_ready, 0);
        chk("rst_h0_aready", h_o[0].a_ready, 0);
        rst = 1'b0;
        settle();
        chk("idle_dready", d_o.d_ready, 1);
        chk("idle_avalid", d_o.a_valid, 0);

        // Single Get from host0, device answers on the third WAIT cycle.
        host(0, 1'b1, Get, 8'h05);
        settle();
        chk("t1_no_avalid_yet", d_o.a_valid, 0);
        tick();
        settle();
        chk("t1_avalid", d_o.a_valid, 1);
        chk("t1_addr", d_o.a_address, 32'h4000_0000);
        chk("t1_grant", grant, 2'b01);
        chk("t1_aready", h_o[0].a_ready, 1);
        tick();
        host(0, 1'b0, Get, 8'h05);
        settle();
        chk("t1_wait_avalid", d_o.a_valid, 0);
        tick();
        tick();
        dev(1'b1, AccessAckData, 8'h05, 32'hDEAD_BEEF);
        settle();
        chk("t1_h0_dvalid", h_o[0].d_valid, 1);
        chk("t1_h0_data", h_o[0].d_data, 32'hDEAD_BEEF);
        chk("t1_h0_op", h_o[0].d_opcode, AccessAckData);
        chk("t1_h1_dvalid", h_o[1].d_valid, 0);
        tick();
        dev(1'b0, AccessAck, 8'h00, 32'h0);
        settle();
        chk("t1_grant_end", grant, 2'b00);
        chk("t1_busy_end", busy, 0);

        // Stray response while idle.
        dev(1'b1, AccessAckData, 8'h33, 32'h1);
        settle();
        chk("st_pulse", stray, 1);
        chk("st_h0", h_o[0].d_valid, 0);
        chk("st_h1", h_o[1].d_valid, 0);
        tick();
        dev(1'b0, AccessAck, 8'h00, 32'h0);
        settle();
        chk("st_pulse_end", stray, 0);
        chk("st_idle", busy, 0);

        // Both hosts request continuously from reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        host(0, 1'b1, Get, 8'h10);
        host(1, 1'b1, Get, 8'h21);
        for (int t = 0; t < 6; t++) begin
            tick();
            settle();
            chk("rr_grant", grant, (t % 2 == 1) ? 2'b10 : 2'b01);
            chk("rr_asrc", d_o.a_source, (t % 2 == 1) ? 8'h21 : 8'h10);
            cap = d_o.a_source;
            tick();
            dev(1'b1, AccessAckData, cap, 32'(t));
            settle();
            chk("rr_dvalid", h_o[t % 2].d_valid, 1);
            chk("rr_dsrc", h_o[t % 2].d_source, (t % 2 == 1) ? 8'h21 : 8'h10);
            chk("rr_other", h_o[1 - (t % 2)].d_valid, 0);
            tick();
            dev(1'b0, AccessAck, 8'h00, 32'h0);
        end
        host(0, 1'b0, Get, 8'h10);
        host(1, 1'b0, Get, 8'h21);

        // Device stalls a_ready for 5 ISSUE cycles.
        hs = 0;
        d_i.a_ready = 1'b0;
        host(0, 1'b1, PutFullData, 8'h03);
        tick();
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("st5_avalid", d_o.a_valid, 1);
            chk("st5_grant", grant, 2'b01);
            chk("st5_aready", h_o[0].a_ready, 0);
            if (d_o.a_valid && d_i.a_ready) hs++;
            tick();
        end
        d_i.a_ready = 1'b1;
        settle();
        chk("st5_aready_go", h_o[0].a_ready, 1);
        if (d_o.a_valid && d_i.a_ready) hs++;
        tick();
        host(0, 1'b0, PutFullData, 8'h03);
        settle();
        if (d_o.a_valid && d_i.a_ready) hs++;
        chk("st5_one_hs", hs, 1);
        chk("st5_busy", busy, 1);
        dev(1'b1, AccessAck, 8'h03, 32'h0);
        settle();
        chk("st5_rsp", h_o[0].d_valid, 1);
        tick();
        dev(1'b0, AccessAck, 8'h00, 32'h0);

        // Reset during WAIT of a host1 transaction (rr_ptr is 1 here).
        host(1, 1'b1, Get, 8'h55);
        tick();
        tick();
        host(1, 1'b0, Get, 8'h55);
        settle();
        chk("rw_grant", grant, 2'b10);
        chk("rw_busy", busy, 1);
        rst = 1'b1;
        dev(1'b1, AccessAckData, 8'h55, 32'h9);
        settle();
        chk("rw_h1_dvalid", h_o[1].d_valid, 0);
        chk("rw_dready", d_o.d_ready, 0);
        chk("rw_grant0", grant, 0);
        tick();
        rst = 1'b0;
        dev(1'b0, AccessAck, 8'h00, 32'h0);
        settle();
        chk("rw_busy_after", busy, 0);
        chk("rw_grant_after", grant, 0);
        chk("rw_avalid_after", d_o.a_valid, 0);
        host(0, 1'b1, Get, 8'h0A);
        host(1, 1'b1, Get, 8'h21);
        tick();
        settle();
        chk("rw_ptr_reset", grant, 2'b01);
        host(1, 1'b0, Get, 8'h21);
        tick();
        host(0, 1'b0, Get, 8'h0A);
        dev(1'b1, AccessAckData, 8'h0A, 32'h1234_5678);
        settle();
        chk("rw_h0_data", h_o[0].d_data, 32'h1234_5678);
        chk("rw_h0_dvalid", h_o[0].d_valid, 1);
        tick();
        dev(1'b0, AccessAck, 8'h00, 32'h0);

        // Watchdog: host1 PutFullData never answered, late response drained.
        host(1, 1'b1, PutFullData, 8'h07);
        tick();
        tick();
        host(1, 1'b0, PutFullData, 8'h07);
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("to_quiet", h_o[1].d_valid, 0);
            chk("to_no_pulse", tmo, 0);
            tick();
        end
        settle();
        chk("to_dvalid", h_o[1].d_valid, 1);
        chk("to_derror", h_o[1].d_error, 1);
        chk("to_op", h_o[1].d_opcode, AccessAck);
        chk("to_src", h_o[1].d_source, 8'h07);
        chk("to_data", h_o[1].d_data, 32'h0);
        chk("to_dev_dready", d_o.d_ready, 0);
        chk("to_pulse", tmo, 1);
        chk("to_h0", h_o[0].d_valid, 0);
        tick();
        settle();
        chk("dr_pulse_end", tmo, 0);
        chk("dr_busy", busy, 1);
        chk("dr_dready", d_o.d_ready, 1);
        chk("dr_h1_quiet", h_o[1].d_valid, 0);
        tick();
        tick();
        dev(1'b1, AccessAck, 8'h07, 32'h0);
        settle();
        chk("dr_late_h0", h_o[0].d_valid, 0);
        chk("dr_late_h1", h_o[1].d_valid, 0);
        chk("dr_no_stray", stray, 0);
        tick();
        dev(1'b0, AccessAck, 8'h00, 32'h0);
        settle();
        chk("dr_idle", busy, 0);
        chk("dr_grant", grant, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
